// File: rtl/draw_sequencer.sv
// draw_sequencer: one-pixel-per-clock plotter for the vga_adapter, cycling
// through player heads + timer bar, a full-screen clear, then glyph rendering.
module draw_sequencer #(
    parameter int NUM_PLAYERS = 4,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int TIMER_Y     = 119,
    parameter int NUM_GLYPHS  = 4,
    parameter int GLYPH_W     = 5,
    parameter int GLYPH_H     = 7
) (
    input  logic                                 CLOCK_50,
    input  logic                                 resetn,
    input  logic                                 running,
    input  logic                                 restart,
    input  logic [NUM_PLAYERS*(X_W+Y_W)-1:0]     p_pos,
    input  logic [NUM_PLAYERS*3-1:0]             p_colour,
    input  logic [X_W-1:0]                       timer_x,
    input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyph_bits,
    input  logic [NUM_GLYPHS*(X_W+Y_W)-1:0]      glyph_org,
    output logic [X_W-1:0]                       x,
    output logic [Y_W-1:0]                       y,
    output logic [2:0]                           colour,
    output logic                                 plot,
    output logic [1:0]                           phase,
    output logic                                 done
);
    localparam int PW = X_W + Y_W;
    localparam int GB = GLYPH_W * GLYPH_H;
    localparam int SW = $clog2(NUM_PLAYERS + 1);
    localparam int GW = $clog2(NUM_GLYPHS + 1);
    localparam int RW = $clog2(GLYPH_H + 1);
    localparam int CW = $clog2(GLYPH_W + 1);
    typedef enum logic [1:0] {PLAY, CLEAR, GLYPH, DONE} state_t;
    state_t state;
    logic [SW-1:0] s;
    logic [X_W-1:0] cx, nx;
    logic [Y_W-1:0] cy, ny;
    logic [RW-1:0] r;
    logic [CW-1:0] c;
    logic [GW-1:0] g;
    logic [2:0] ncol;
    logic [PW-1:0] pp, go;
    int sel;
    logic p_last, cy_end, c_last, g_end, c_end, g_last, gbit, on_screen;
    assign phase = state;
    assign done = state == DONE;
    always_comb begin
        p_last = s == SW'(NUM_PLAYERS);
        sel = p_last ? 0 : int'(s);
        pp = PW'(p_pos >> (sel * PW));
        go = PW'(glyph_org >> (int'(g) * PW));
        gbit = 1'(glyph_bits >> (int'(g) * GB + GB - 1 - int'(r) * GLYPH_W - int'(c)));
        cy_end = cy == Y_W'(SCREEN_H - 1);
        c_last = cy_end && cx == X_W'(SCREEN_W - 1);
        g_end = g == GW'(NUM_GLYPHS - 1);
        c_end = c == CW'(GLYPH_W - 1);
        g_last = g_end && c_end && r == RW'(GLYPH_H - 1);
        nx = x;
        ny = y;
        ncol = colour;
        case (state)
            PLAY: begin
                nx = p_last ? timer_x : pp[PW-1 -: X_W];
                ny = p_last ? Y_W'(TIMER_Y) : pp[Y_W-1:0];
                ncol = p_last ? 3'b111 : 3'(p_colour >> (sel * 3));
            end
            CLEAR: begin
                nx = cx;
                ny = cy;
                ncol = 3'b000;
            end
            GLYPH: begin
                nx = go[PW-1 -: X_W] + X_W'(c);
                ny = go[Y_W-1:0] + Y_W'(r);
                ncol = {3{gbit}};
            end
            default: ;
        endcase
        on_screen = int'(nx) < SCREEN_W && int'(ny) < SCREEN_H;
    end
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= PLAY;
            s <= '0;
            cx <= '0;
            cy <= '0;
            r <= '0;
            c <= '0;
            g <= '0;
            x <= '0;
            y <= '0;
            colour <= '0;
            plot <= 1'b0;
        end else begin
            x <= nx;
            y <= ny;
            colour <= ncol;
            plot <= state != DONE && on_screen;
            case (state)
                PLAY: begin
                    s <= p_last ? '0 : s + 1'b1;
                    if (p_last && !running) state <= CLEAR;
                end
                CLEAR: begin
                    cy <= cy_end ? '0 : cy + 1'b1;
                    if (cy_end) cx <= c_last ? '0 : cx + 1'b1;
                    if (c_last) state <= GLYPH;
                end
                GLYPH: begin
                    g <= g_end ? '0 : g + 1'b1;
                    if (g_end) c <= c_end ? '0 : c + 1'b1;
                    if (g_end && c_end) r <= g_last ? '0 : r + 1'b1;
                    if (g_last) state <= DONE;
                end
                default: if (restart) state <= PLAY;
            endcase
        end
    end
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: random-stimulus bench comparing draw_sequencer against a
// pixel-index reference model of the play/clear/glyph/done sequence.
module tb_draw_sequencer;
    localparam int NP = 4, NG = 4, GWD = 5, GHT = 7, GB = GWD * GHT;
    localparam int SCW = 160, SCH = 120;
    logic CLOCK_50 = 1'b0;
    logic resetn = 1'b1, running = 1'b1, restart = 1'b0;
    logic [NP*15-1:0] p_pos;
    logic [NP*3-1:0] p_colour;
    logic [7:0] timer_x;
    logic [NG*GB-1:0] glyph_bits;
    logic [NG*15-1:0] glyph_org;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic plot, done;
    logic [1:0] phase;
    int px[NP], py[NP], pc[NP], ox[NG], oy[NG];
    logic [GB-1:0] gb[NG];
    int m_mode, m_k, ex, ey, ec;
    bit e_xy, ep;
    int n_tests = 0, n_fail = 0;

    draw_sequencer dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .running(running), .restart(restart),
        .p_pos(p_pos), .p_colour(p_colour), .timer_x(timer_x),
        .glyph_bits(glyph_bits), .glyph_org(glyph_org),
        .x(x), .y(y), .colour(colour), .plot(plot), .phase(phase), .done(done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < NP; i++) begin
            p_pos[i*15 +: 15] = {px[i][7:0], py[i][6:0]};
            p_colour[i*3 +: 3] = pc[i][2:0];
        end
        for (int i = 0; i < NG; i++) begin
            glyph_bits[i*GB +: GB] = gb[i];
            glyph_org[i*15 +: 15] = {ox[i][7:0], oy[i][6:0]};
        end
    endtask

    task automatic rand_players();
        for (int i = 0; i < NP; i++) begin
            px[i] = $urandom_range(0, 199);
            py[i] = $urandom_range(0, 127);
            pc[i] = $urandom_range(0, 7);
        end
        timer_x = 8'($urandom_range(0, 255));
        pack();
    endtask

    // Expected pixel for the edge just taken, derived from the pixel index m_k.
    task automatic step();
        int sl, gi, ci, ri;
        e_xy = 1'b1;
        case (m_mode)
            0: begin
                sl = m_k % (NP + 1);
                if (sl < NP) begin
                    ex = px[sl]; ey = py[sl]; ec = pc[sl];
                end else begin
                    ex = int'(timer_x); ey = 119; ec = 7;
                end
                m_k++;
                if (sl == NP && !running) begin m_mode = 1; m_k = 0; end
            end
            1: begin
                ex = m_k / SCH; ey = m_k % SCH; ec = 0;
                m_k++;
                if (m_k == SCW * SCH) begin m_mode = 2; m_k = 0; end
            end
            2: begin
                gi = m_k % NG; ci = (m_k / NG) % GWD; ri = m_k / (NG * GWD);
                ex = (ox[gi] + ci) % 256; ey = (oy[gi] + ri) % 128;
                ec = gb[gi][GB-1-(ri*GWD+ci)] ? 7 : 0;
                m_k++;
                if (m_k == NG * GB) begin m_mode = 3; m_k = 0; end
            end
            default: begin
                e_xy = 1'b0;
                if (restart) begin m_mode = 0; m_k = 0; end
            end
        endcase
        ep = e_xy && ex < SCW && ey < SCH;
    endtask

    task automatic cycle();
        @(posedge CLOCK_50);
        step();
        @(negedge CLOCK_50);
        chk("phase", int'(phase), m_mode);
        chk("done", int'(done), int'(m_mode == 3));
        chk("plot", int'(plot), int'(ep));
        if (e_xy) begin
            chk("x", int'(x), ex);
            chk("y", int'(y), ey);
            chk("colour", int'(colour), ec);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_x"}, int'(x), 0);
        chk({tag, "_y"}, int'(y), 0);
        chk({tag, "_colour"}, int'(colour), 0);
        chk({tag, "_plot"}, int'(plot), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_phase"}, int'(phase), 0);
    endtask

    initial begin
        int n;
        px = '{10, 30, 50, 70};
        py = '{20, 40, 60, 80};
        pc = '{1, 2, 3, 4};
        timer_x = 8'd5;
        gb[0] = 35'b11100_00100_00100_00100_00100_00100_11111;
        ox[0] = 33; oy[0] = 42;
        for (int i = 1; i < NG; i++) begin
            gb[i] = GB'({$urandom, $urandom});
            ox[i] = $urandom_range(0, 255);
            oy[i] = $urandom_range(0, 127);
        end
        ox[3] = 157; oy[3] = 118;
        pack();
        m_mode = 0; m_k = 0;
        #2 resetn = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        check_reset("rst");
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) cycle();
        px[2] = 200;
        pack();
        for (int i = 0; i < 10; i++) cycle();
        for (int i = 0; i < 40; i++) begin
            rand_players();
            cycle();
        end
        // Drop running so the next edge processes slot 1.
        while (m_k % (NP + 1) != 1) cycle();
        running = 1'b0;
        n = 0;
        while (m_mode == 0 && n < 20) begin cycle(); n++; end
        chk("enter_clear", m_mode, 1);
        n = 0;
        while (m_mode == 1 && n < 20000) begin
            restart = (n == 300);
            running = 1'($urandom);
            cycle();
            n++;
        end
        restart = 1'b0;
        chk("clear_len", n, SCW * SCH);
        n = 0;
        while (m_mode == 2 && n < 200) begin cycle(); n++; end
        chk("glyph_len", n, NG * GB);
        for (int i = 0; i < 5; i++) cycle();
        restart = 1'b1;
        running = 1'b1;
        cycle();
        restart = 1'b0;
        for (int i = 0; i < 25; i++) begin
            rand_players();
            running = ($urandom_range(0, 9) != 0);
            cycle();
        end
        running = 1'b0;
        n = 0;
        while (m_mode == 0 && n < 20) begin cycle(); n++; end
        for (int i = 0; i < 5000; i++) cycle();
        #2 resetn = 1'b0;
        #1 check_reset("async_rst");
        @(negedge CLOCK_50);
        check_reset("held_rst");
        m_mode = 0; m_k = 0;
        running = 1'b1;
        resetn = 1'b1;
        for (int i = 0; i < 15; i++) begin
            rand_players();
            cycle();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
